// File: rtl/imem_loader_if.sv
// Bus bundle for imem_loader: start pulse, upstream byte stream, instruction-memory
// write port and session status. master = loader side, slave = environment side.
interface imem_loader_if #(
  parameter int ADDR_W = 6
);
  logic              start;
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              core_hold;
  logic              done;
  logic              error;
  logic [ADDR_W:0]   word_count;

  modport master (
    input  start, in_valid, in_data,
    output in_ready, imem_we, imem_addr, imem_wdata,
    output core_hold, done, error, word_count
  );

  modport slave (
    output start, in_valid, in_data,
    input  in_ready, imem_we, imem_addr, imem_wdata,
    input  core_hold, done, error, word_count
  );
endinterface

// File: rtl/imem_loader.sv
// Boot loader: receives a length byte plus little-endian instruction words and writes
// them to instruction memory while holding the core. Optional trailing XOR checksum: IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6
) (
  input  logic           clk,
  input  logic           reset,
  imem_loader_if.master  bus
);

  typedef enum logic [2:0] {
    IDLE,
    LEN,
    DATA,
    WRITE,
    CSUM,
    DONE,
    ERR
  } state_t;

  localparam logic [ADDR_W:0] WC_ONE = (ADDR_W+1)'(1);

  state_t          state_reg, state_next;
  logic [1:0]      byte_idx_reg, byte_idx_next;
  logic [31:0]     word_reg, word_next;
  logic [ADDR_W:0] len_reg, len_next;
  logic [ADDR_W:0] word_count_reg, word_count_next;
  logic [ADDR_W:0] word_count_inc;
  logic [31:0]     len_byte;
  logic            ready;
  logic            accept;
  logic            data_accept;

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]      csum_reg, csum_next;
`endif

  // in_ready depends on state only, never on in_valid
  assign ready          = (state_reg == LEN) || (state_reg == DATA) || (state_reg == CSUM);
  assign accept         = ready && bus.in_valid;
  assign data_accept    = accept && (state_reg == DATA);
  assign len_byte       = {24'd0, bus.in_data};
  assign word_count_inc = word_count_reg + WC_ONE;

  // Each byte lane captures the incoming byte only when it is the addressed lane
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign word_next[8*gi +: 8] = (data_accept && (byte_idx_reg == 2'(gi)))
                                    ? bus.in_data : word_reg[8*gi +: 8];
    end
  endgenerate

  always_comb begin
    state_next      = state_reg;
    byte_idx_next   = byte_idx_reg;
    len_next        = len_reg;
    word_count_next = word_count_reg;
`ifdef IMEM_LOADER_CHECKSUM_EN
    csum_next       = csum_reg;
`endif
    case (state_reg)
      IDLE, DONE, ERR: begin
        if (bus.start) begin
          state_next      = LEN;
          byte_idx_next   = 2'd0;
          word_count_next = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
          csum_next       = 8'd0;
`endif
        end
      end
      LEN: begin
        if (accept) begin
          if ((len_byte >= 32'd1) && (len_byte <= 32'(DEPTH))) begin
            state_next = DATA;
            len_next   = len_byte[ADDR_W:0];
          end else begin
            state_next = ERR;
          end
        end
      end
      DATA: begin
        if (accept) begin
          byte_idx_next = byte_idx_reg + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
          csum_next     = csum_reg ^ bus.in_data;
`endif
          if (byte_idx_reg == 2'd3) begin
            state_next = WRITE;
          end
        end
      end
      WRITE: begin
        word_count_next = word_count_inc;
        if (word_count_inc < len_reg) begin
          state_next = DATA;
        end else begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          state_next = CSUM;
`else
          state_next = DONE;
`endif
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      CSUM: begin
        if (accept) begin
          state_next = (bus.in_data == csum_reg) ? DONE : ERR;
        end
      end
`endif
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg      <= IDLE;
      byte_idx_reg   <= 2'd0;
      word_reg       <= 32'd0;
      len_reg        <= '0;
      word_count_reg <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_reg       <= 8'd0;
`endif
    end else begin
      state_reg      <= state_next;
      byte_idx_reg   <= byte_idx_next;
      word_reg       <= word_next;
      len_reg        <= len_next;
      word_count_reg <= word_count_next;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_reg       <= csum_next;
`endif
    end
  end

  assign bus.in_ready   = ready;
  assign bus.imem_we    = (state_reg == WRITE);
  assign bus.imem_addr  = word_count_reg[ADDR_W-1:0];
  assign bus.imem_wdata = word_reg;
  assign bus.core_hold  = (state_reg != DONE);
  assign bus.done       = (state_reg == DONE);
  assign bus.error      = (state_reg == ERR);
  assign bus.word_count = word_count_reg;

endmodule

// File: tb/tb_imem_loader.sv
// Randomized self-checking bench for imem_loader; expected writes and final status
// come from a stream-level model of the load protocol.
module tb_imem_loader;
  localparam int DEPTH  = 64;
  localparam int ADDR_W = 6;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  imem_loader_if #(.ADDR_W(ADDR_W)) bus ();

  imem_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // observed writes and back-to-back strobe detector
  int          wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  int          we_double = 0;
  logic        we_prev   = 1'b0;

  always @(negedge clk) begin
    if (bus.imem_we === 1'b1) begin
      wr_addr_q.push_back(int'(bus.imem_addr));
      wr_data_q.push_back(bus.imem_wdata);
      if (we_prev === 1'b1) we_double <= we_double + 1;
    end
    we_prev <= bus.imem_we;
  end

  // stimulus stream and model expectations
  logic [7:0]  stim_q[$];
  int          exp_addr_q[$];
  logic [31:0] exp_data_q[$];
  logic        exp_done;
  logic        exp_error;
  int          exp_wc;

  function automatic logic [7:0] data_xor();
    logic [7:0] x = 8'd0;
    int n = int'(stim_q[0]);
    for (int i = 1; i <= 4*n && i < stim_q.size(); i++) x = x ^ stim_q[i];
    return x;
  endfunction

  function automatic void build_model();
    int n = int'(stim_q[0]);
    exp_addr_q.delete();
    exp_data_q.delete();
    if (n < 1 || n > DEPTH) begin
      exp_done  = 1'b0;
      exp_error = 1'b1;
      exp_wc    = 0;
      return;
    end
    for (int k = 0; k < n; k++) begin
      exp_addr_q.push_back(k);
      exp_data_q.push_back({stim_q[4*k+4], stim_q[4*k+3], stim_q[4*k+2], stim_q[4*k+1]});
    end
    exp_wc = n;
`ifdef IMEM_LOADER_CHECKSUM_EN
    exp_done  = (stim_q[4*n+1] == data_xor());
    exp_error = !exp_done;
`else
    exp_done  = 1'b1;
    exp_error = 1'b0;
`endif
  endfunction

  function automatic void add_checksum();
`ifdef IMEM_LOADER_CHECKSUM_EN
    stim_q.push_back(data_xor());
`endif
  endfunction

  task automatic do_reset();
    bus.start    = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'd0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    wr_addr_q.delete();
    wr_data_q.delete();
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // offer one byte at a negedge; returns at the negedge after it is taken
  task automatic send_byte(input logic [7:0] b, output bit ok);
    int waitc = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    while (bus.in_ready !== 1'b1 && waitc < 20) begin
      @(negedge clk);
      waitc++;
    end
    if (bus.in_ready !== 1'b1) begin
      ok = 1'b0;
    end else begin
      @(negedge clk);
      ok = 1'b1;
    end
    bus.in_valid = 1'b0;
    bus.in_data  = 8'($urandom);
  endtask

  task automatic send_range(input int first, input int last, input int max_gap);
    bit ok;
    int n = int'(stim_q[0]);
    for (int i = first; i <= last; i++) begin
      repeat ($urandom_range(0, max_gap)) @(negedge clk);
      send_byte(stim_q[i], ok);
      checks++;
      if (!ok) begin
        failures++;
        $display("FAIL byte_accept idx=%0d in_ready got=0 want=1", i);
        return;
      end
      if (n >= 1 && n <= DEPTH && i >= 4 && i <= 4*n && (i % 4) == 0) begin
        checks++;
        if (bus.imem_we !== 1'b1 || bus.in_ready !== 1'b0 || bus.imem_addr !== ADDR_W'(i/4 - 1)) begin
          failures++;
          $display("FAIL write_latency idx=%0d we=%b ready=%b addr=%0d want we=1 ready=0 addr=%0d",
                   i, bus.imem_we, bus.in_ready, bus.imem_addr, i/4 - 1);
        end
      end
    end
  endtask

  task automatic finish_check(input string name);
    repeat (3) @(negedge clk);
    checks++;
    if (wr_addr_q.size() != exp_addr_q.size()) begin
      failures++;
      $display("FAIL %s write_count got=%0d want=%0d", name, wr_addr_q.size(), exp_addr_q.size());
    end else begin
      for (int i = 0; i < exp_addr_q.size(); i++) begin
        checks++;
        if (wr_addr_q[i] != exp_addr_q[i] || wr_data_q[i] !== exp_data_q[i]) begin
          failures++;
          $display("FAIL %s write[%0d] got=%0d:%08h want=%0d:%08h", name, i,
                   wr_addr_q[i], wr_data_q[i], exp_addr_q[i], exp_data_q[i]);
        end
      end
    end
    checks++;
    if (bus.done !== exp_done || bus.error !== exp_error || bus.core_hold !== !exp_done ||
        bus.word_count !== (ADDR_W+1)'(exp_wc)) begin
      failures++;
      $display("FAIL %s status got done=%b err=%b hold=%b wc=%0d want done=%b err=%b hold=%b wc=%0d",
               name, bus.done, bus.error, bus.core_hold, bus.word_count,
               exp_done, exp_error, !exp_done, exp_wc);
    end
    $display("txn %s writes=%0d done=%b error=%b wc=%0d", name, wr_addr_q.size(),
             bus.done, bus.error, bus.word_count);
  endtask

  task automatic check_reset_outputs(input string name);
    checks++;
    if (bus.in_ready !== 1'b0 || bus.imem_we !== 1'b0 || bus.imem_addr !== '0 ||
        bus.imem_wdata !== 32'd0 || bus.core_hold !== 1'b1 || bus.done !== 1'b0 ||
        bus.error !== 1'b0 || bus.word_count !== '0) begin
      failures++;
      $display("FAIL %s outputs got rdy=%b we=%b addr=%0d wd=%08h hold=%b done=%b err=%b wc=%0d want 0 0 0 0 1 0 0 0",
               name, bus.in_ready, bus.imem_we, bus.imem_addr, bus.imem_wdata,
               bus.core_hold, bus.done, bus.error, bus.word_count);
    end
  endtask

  task automatic test_reset();
    bus.start = 1'b0; bus.in_valid = 1'b0; bus.in_data = 8'd0;
    @(negedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    reset = 1'b0;
    @(negedge clk);
    check_reset_outputs("idle_after_reset");
  endtask

  task automatic test_basic();
    int seen_ready = 0;
    do_reset();
    pulse_start();
    stim_q = '{8'h02, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    add_checksum();
    build_model();
    send_range(0, stim_q.size() - 1, 0);
    finish_check("basic");
    checks++;
    if (wr_data_q.size() != 2 || wr_data_q[0] !== 32'h00000013 || wr_data_q[1] !== 32'h00100093) begin
      failures++;
      $display("FAIL basic_words got n=%0d want 00000013,00100093", wr_data_q.size());
    end
    // a trailing byte after DONE must not be taken
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h5A;
    repeat (5) begin
      if (bus.in_ready === 1'b1) seen_ready++;
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    checks++;
    if (seen_ready != 0 || bus.done !== 1'b1) begin
      failures++;
      $display("FAIL trailing_byte ready_cycles got=%0d done=%b want 0 1", seen_ready, bus.done);
    end
  endtask

  task automatic test_bad_header();
    logic [7:0] hdrs[3] = '{8'h00, 8'h41, 8'hFF};
    foreach (hdrs[h]) begin
      do_reset();
      pulse_start();
      stim_q = '{hdrs[h]};
      build_model();
      send_range(0, 0, 0);
      checks++;
      if (bus.error !== 1'b1 || bus.core_hold !== 1'b1 || bus.done !== 1'b0 || bus.in_ready !== 1'b0) begin
        failures++;
        $display("FAIL bad_header %02h got err=%b hold=%b done=%b rdy=%b want 1 1 0 0",
                 hdrs[h], bus.error, bus.core_hold, bus.done, bus.in_ready);
      end
      finish_check($sformatf("bad_header_%02h", hdrs[h]));
    end
  endtask

  task automatic test_random_sessions();
    for (int s = 0; s < 4; s++) begin
      int n = (s == 0) ? DEPTH : int'($urandom_range(1, 8));
      int dbl_base;
      do_reset();
      dbl_base = we_double;
      pulse_start();
      stim_q = '{8'(n)};
      for (int i = 0; i < 4*n; i++) stim_q.push_back(8'($urandom));
      add_checksum();
      build_model();
      send_range(0, stim_q.size() - 1, 2);
      finish_check($sformatf("random_n%0d", n));
      checks++;
      if (we_double != dbl_base) begin
        failures++;
        $display("FAIL we_pulse_width long_strobes got=%0d want=0", we_double - dbl_base);
      end
    end
  endtask

  task automatic test_reset_mid();
    int seen_ready = 0;
    do_reset();
    pulse_start();
    stim_q = '{8'h05};
    for (int i = 0; i < 20; i++) stim_q.push_back(8'($urandom));
    send_range(0, 14, 1);
    reset = 1'b1;
    #1;
    check_reset_outputs("mid_reset_async");
    @(negedge clk);
    reset = 1'b0;
    wr_addr_q.delete();
    wr_data_q.delete();
    bus.in_valid = 1'b1;
    repeat (10) begin
      bus.in_data = 8'($urandom);
      if (bus.in_ready === 1'b1) seen_ready++;
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    checks++;
    if (seen_ready != 0 || wr_addr_q.size() != 0) begin
      failures++;
      $display("FAIL after_reset_quiet got ready=%0d writes=%0d want 0 0", seen_ready, wr_addr_q.size());
    end
    pulse_start();
    stim_q = '{8'h01, 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom)};
    add_checksum();
    build_model();
    send_range(0, stim_q.size() - 1, 1);
    finish_check("reset_then_single");
  endtask

  task automatic test_start_ignored();
    do_reset();
    pulse_start();
    stim_q = '{8'h03};
    for (int i = 0; i < 12; i++) stim_q.push_back(8'($urandom));
    add_checksum();
    build_model();
    send_range(0, 5, 0);
    pulse_start();
    send_range(6, stim_q.size() - 1, 1);
    finish_check("start_mid_data");
    pulse_start();
    checks++;
    if (bus.done !== 1'b0 || bus.core_hold !== 1'b1 || bus.in_ready !== 1'b1 ||
        bus.error !== 1'b0 || bus.word_count !== '0) begin
      failures++;
      $display("FAIL restart_from_done got done=%b hold=%b rdy=%b err=%b wc=%0d want 0 1 1 0 0",
               bus.done, bus.core_hold, bus.in_ready, bus.error, bus.word_count);
    end
  endtask

`ifdef IMEM_LOADER_CHECKSUM_EN
  task automatic test_checksum();
    do_reset();
    pulse_start();
    stim_q = '{8'h01, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hFF};
    build_model();
    send_range(0, stim_q.size() - 1, 0);
    finish_check("bad_checksum");
    checks++;
    if (wr_data_q.size() != 1 || wr_data_q[0] !== 32'hDDCCBBAA || bus.error !== 1'b1) begin
      failures++;
      $display("FAIL bad_checksum_word got n=%0d err=%b want 1 word DDCCBBAA err=1",
               wr_data_q.size(), bus.error);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_bad_header();
    test_random_sessions();
    test_reset_mid();
    test_start_ignored();
`ifdef IMEM_LOADER_CHECKSUM_EN
    test_checksum();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
